// File: rtl/irq_controller.sv
// irq_controller: six-source prioritizing interrupt controller for CP0.
// Device-bus slave, register select on Addr[3:2]: PEND, MASK, STAT, EOI.
// Source 0 has the highest priority. A request is held until CP0 acks,
// then the source stays in service until software writes EOI.
// Build option: define IRQ_EDGE_EN for edge-latched PEND with W1C clears;
// the default build latches PEND as a level copy of the irq lines.
//
// state   | meaning
// IDLE    | nothing requested; picks the winner when any source is eligible
// REQ     | int_req high for int_id, waiting for int_ack or withdrawal
// SERVICE | CP0 owns int_id; waits for the EOI write
module irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  input  logic [5:0]  irq,
  input  logic        int_ack,
  output logic        int_req,
  output logic [2:0]  int_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  id_next;
  logic [5:0]  pend;
  logic [5:0]  mask;
  logic [5:0]  irq_q;
  logic [5:0]  eligible;
  logic [2:0]  winner;
  logic        in_service;
  logic        wr_pend;
  logic        wr_mask;
  logic        wr_eoi;
  logic        ack_take;
  logic        unused_bits;

  assign eligible   = pend & mask;
  assign in_service = (state == SERVICE);
  assign wr_pend    = WE && (Addr[3:2] == 2'd0);
  assign wr_mask    = WE && (Addr[3:2] == 2'd1);
  assign wr_eoi     = WE && (Addr[3:2] == 2'd3);
  assign ack_take   = (state == REQ) && int_ack;

  // Bits outside the register window and data field are decoded upstream.
  assign unused_bits = ^{Addr[31:4], Addr[1:0], WD[31:6]};

  // Fixed priority: scanning from the top leaves the lowest set index.
  always_comb begin
    winner = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Next-state: ack beats withdrawal, int_id frozen while requesting.
  always_comb begin
    state_next = state;
    id_next    = int_id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = REQ;
          id_next    = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_next = SERVICE;
        end else if (!eligible[int_id]) begin
          state_next = IDLE;
          id_next    = 3'd0;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_next = IDLE;
          id_next    = 3'd0;
        end
      end
      default: begin
        state_next = IDLE;
        id_next    = 3'd0;
      end
    endcase
  end

  // State, request and id registers; int_req mirrors entry into REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      int_id  <= 3'd0;
      int_req <= 1'b0;
    end else begin
      state   <= state_next;
      int_id  <= id_next;
      int_req <= (state_next == REQ);
    end
  end

  // Input history for edge detection, and the software mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 6'd0;
      mask  <= 6'd0;
    end else begin
      irq_q <= irq;
      if (wr_mask) mask <= WD[5:0];
    end
  end

`ifdef IRQ_EDGE_EN
  logic [5:0] pend_set;
  logic [5:0] pend_clr;

  assign pend_set = irq & ~irq_q;
  assign pend_clr = (wr_pend ? WD[5:0] : 6'd0) |
                    (ack_take ? (6'b000001 << int_id) : 6'd0);

  // Sticky pending bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 6'd0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end
`else
  logic unused_level;

  // PEND writes and acks have no effect on a level copy.
  assign unused_level = wr_pend ^ ack_take;

  // Level mode: PEND simply follows the lines one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 6'd0;
    end else begin
      pend <= irq;
    end
  end
`endif

  // Combinational read mux; EOI and unused bits read as zero.
  always_comb begin
    RD = 32'd0;
    case (Addr[3:2])
      2'd0:    RD = {26'd0, pend};
      2'd1:    RD = {26'd0, mask};
      2'd2:    RD = {28'd0, in_service, int_id};
      default: RD = 32'd0;
    endcase
  end

endmodule
